la_iotxdiff_ctrl: RTL and testbench
===================================

// Module: la_iotxdiff_ctrl
// PURPOSE
// Transmit sequencer for one differential TX pad cell. Accepts DW-bit words over a
// valid/ready handshake and drives the pad's data and output-enable pins. Per burst:
// warm-up with line held low, alternating preamble, LSB-first serial data, low tail.
// Sits in core logic directly in front of the TX pad cell; one pad per instance.
// PARAMETERS
// DW    8  data word width, >=2
// WARM  2  cycles of oe=1, a=0 before the preamble, >=1
// PRE   4  preamble bits, pattern 1,0,1,0..., >=0 (0 = no preamble)
// HOLD  3  tail cycles of oe=1, a=0 after the last data bit, >=1
// PORTS
// clk       in   1   core clock, all logic on rising edge
// reset     in   1   synchronous active-high reset
// en        in   1   transmit enable; gates acceptance of new words
// in_valid  in   1   word available
// in_data   in   DW  word to send, bit 0 first
// in_ready  out  1   word accepted on clk edge where in_valid & in_ready
// tx_a      out  1   pad data (pad cell input a)
// tx_oe     out  1   pad output enable (pad cell input oe)
// busy      out  1   state != IDLE
// BEHAVIOUR
// - reset: state=IDLE, tx_a=0, tx_oe=0, busy=0; in_ready=0 while reset is high.
//   Reset mid-burst aborts immediately: next cycle tx_oe=0, and the word is dropped.
// - tx_a and tx_oe are registered outputs (flop outputs, no glitches to the pad).
//   in_ready is combinational from state, counter and en.
// - in_ready = en & (IDLE | TAIL | (DATA & last bit)).
// - IDLE: tx_oe=0, tx_a=0. On accept: load shift reg, go to WARM.
// - WARM: tx_oe=1, tx_a=0 for exactly WARM cycles, then PRE (DATA if PRE=0).
// - PRE: tx_a = 1,0,1,0... for PRE cycles, starting with 1, then DATA.
// - DATA: tx_a = shift_reg[0] for DW cycles, LSB first.
//   On the last bit:
//     - accept -> next word starts in DATA the next cycle; back-to-back, no gap,
//       no preamble.
//     - no accept -> TAIL.
// - TAIL: tx_oe=1, tx_a=0 for HOLD cycles, then IDLE (tx_oe=0).
//   Accept during TAIL -> PRE next cycle (WARM skipped, line still driven).
//   With PRE=0 that accept goes straight to DATA.
// - Latency: accept at edge T from IDLE -> tx_oe=1 at T+1. First data bit at T+1+WARM+PRE.
// - Simultaneous events:
//   - accept has priority over the TAIL/IDLE transitions.
//   - en low mid-burst: current word completes, then TAIL and IDLE as normal.
//   - in_valid high while in_ready low: no state change; in_data is ignored.
// - Counters: single down-counter sized $clog2(max(DW,WARM,PRE,HOLD)+1).
//   Reload on each state entry; no wrap past 0.
// - Frame length from IDLE: WARM+PRE+DW+HOLD cycles of tx_oe=1.
// TESTING (DW=8, WARM=2, PRE=4, HOLD=3)
// 1 reset held 3 cycles with in_valid=1 -> in_ready=0, tx_oe=0, tx_a=0, busy=0 throughout.
// 2 single word 0xA5 accepted at T -> tx_oe=1 for T+1..T+17.
//   tx_a = 0,0 | 1,0,1,0 | 1,0,1,0,0,1,0,1 | 0,0,0; tx_oe=0 at T+18.
// 3 0x3C then 0xFF presented back-to-back -> 0xFF accepted on 0x3C's last bit.
//   Serial stream 0,0,1,1,1,1,0,0 then 1 x8 with no gap; single preamble; one tail.
// 4 second word (0x01) during tail cycle 2 -> no warm-up; preamble 1,0,1,0, then 1,0,0,0,0,0,0,0.
// 5 reset asserted during data bit 4 of 0xA5 -> next cycle tx_oe=0, busy=0.
//   After reset release, in_ready=1 and a new word transmits normally.
// 6 en=0 with in_valid=1 -> never accepted, tx_oe=0.
//   en dropped mid-word -> word finishes, 3-cycle tail, IDLE, no further accepts.

Source files
------------

// File: rtl/la_iotxdiff_ctrl.sv
// Transmit sequencer for one differential TX pad: warm-up, alternating preamble,
// LSB-first serial data, then a driven-low tail, with registered pad pins.
module la_iotxdiff_ctrl #(
  parameter int DW   = 8,
  parameter int WARM = 2,
  parameter int PRE  = 4,
  parameter int HOLD = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic          i_in_valid,
  input  logic [DW-1:0] i_in_data,
  output logic          o_in_ready,
  output logic          o_tx_a,
  output logic          o_tx_oe,
  output logic          o_busy
);

  localparam int MAX_AB = (DW > WARM) ? DW : WARM;
  localparam int MAX_CD = (PRE > HOLD) ? PRE : HOLD;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXC + 1);
  localparam bit HAS_PRE = (PRE > 0);

  localparam logic [CW-1:0] C_WARM = CW'(WARM - 1);
  localparam logic [CW-1:0] C_PRE  = CW'((PRE > 0) ? PRE - 1 : 0);
  localparam logic [CW-1:0] C_DW   = CW'(DW - 1);
  localparam logic [CW-1:0] C_HOLD = CW'(HOLD - 1);

  typedef enum logic [2:0] {S_IDLE, S_WARM, S_PRE, S_DATA, S_TAIL} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_shift, w_shift_nxt;
  logic          r_pbit, w_pbit_nxt;
  logic          r_tx_a, r_tx_oe;
  logic          w_tx_a_nxt;
  logic          w_last;
  logic          w_accept;

  // Counter holds cycles remaining in the current state; zero marks the final cycle.
  assign w_last     = (r_cnt == '0);
  assign o_in_ready = i_en & ~i_reset &
                      ((r_state == S_IDLE) | (r_state == S_TAIL) |
                       ((r_state == S_DATA) & w_last));
  assign w_accept   = o_in_ready & i_in_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_last ? r_cnt : r_cnt - 1'b1;
    w_shift_nxt = r_shift;
    w_pbit_nxt  = ~r_pbit;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_WARM;
          w_cnt_nxt   = C_WARM;
          w_shift_nxt = i_in_data;
        end
      end
      S_WARM: begin
        if (w_last) begin
          if (HAS_PRE) begin
            w_state_nxt = S_PRE;
            w_cnt_nxt   = C_PRE;
            w_pbit_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = C_DW;
          end
        end
      end
      S_PRE: begin
        if (w_last) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = C_DW;
        end
      end
      S_DATA: begin
        if (!w_last) begin
          w_shift_nxt = r_shift >> 1;
        end else if (w_accept) begin
          w_cnt_nxt   = C_DW;
          w_shift_nxt = i_in_data;
        end else begin
          w_state_nxt = S_TAIL;
          w_cnt_nxt   = C_HOLD;
        end
      end
      S_TAIL: begin
        // The line is still driven here, so a new word skips warm-up.
        if (w_accept) begin
          w_shift_nxt = i_in_data;
          if (HAS_PRE) begin
            w_state_nxt = S_PRE;
            w_cnt_nxt   = C_PRE;
            w_pbit_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = C_DW;
          end
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_DATA:  w_tx_a_nxt = w_shift_nxt[0];
      S_PRE:   w_tx_a_nxt = w_pbit_nxt;
      default: w_tx_a_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_pbit  <= 1'b0;
      r_tx_a  <= 1'b0;
      r_tx_oe <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_pbit  <= w_pbit_nxt;
      r_tx_a  <= w_tx_a_nxt;
      r_tx_oe <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_tx_a  = r_tx_a;
  assign o_tx_oe = r_tx_oe;
  assign o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_la_iotxdiff_ctrl.sv
// Directed bench for la_iotxdiff_ctrl (DW=8, WARM=2, PRE=4, HOLD=3); expected pad
// streams are hand-built bit vectors, cycle index 0 being the cycle after the accept.
module tb_la_iotxdiff_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_a;
  logic       tx_oe;
  logic       busy;

  int checks = 0;
  int errors = 0;

  la_iotxdiff_ctrl #(.DW(8), .WARM(2), .PRE(4), .HOLD(3)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_en       (en),
    .i_in_valid (in_valid),
    .i_in_data  (in_data),
    .o_in_ready (in_ready),
    .o_tx_a     (tx_a),
    .o_tx_oe    (tx_oe),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".oe"}, 32'(tx_oe), 32'd0);
    chk({tag, ".a"}, 32'(tx_a), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Walks n frame cycles; optionally raises in_valid with new data after cycle
  // raise_idx and drops it after cycle drop_idx (where in_ready must be high).
  task automatic expect_seq(input string tag, input logic [63:0] seq, input int n,
                            input int raise_idx, input logic [7:0] raise_data,
                            input int drop_idx);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.oe[%0d]", tag, i), 32'(tx_oe), 32'd1);
      chk($sformatf("%s.a[%0d]", tag, i), 32'(tx_a), 32'(seq[i]));
      chk($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'd1);
      if (i == drop_idx) chk($sformatf("%s.ready[%0d]", tag, i), 32'(in_ready), 32'd1);
      tick();
      if (i == raise_idx) begin
        in_valid = 1'b1;
        in_data  = raise_data;
      end
      if (i == drop_idx) in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] s;
    reset    = 1'b1;
    en       = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;

    // 1: reset held with in_valid high
    #1;
    chk("rst.ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst.ready[%0d]", i), 32'(in_ready), 32'd0);
      chk_idle($sformatf("rst[%0d]", i));
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("rst.rel_ready", 32'(in_ready), 32'd1);

    // 2: single word 0xA5
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    s = 64'({3'b000, 8'hA5, 4'b0101, 2'b00});
    expect_seq("a5", s, 17, -1, 8'h00, -1);
    chk_idle("a5.end");
    chk("a5.end_ready", 32'(in_ready), 32'd1);

    // 3: 0x3C then 0xFF back-to-back; 0xFF waits with in_valid high until the last bit
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_data  = 8'hFF;
    chk("b2b.ready_warm", 32'(in_ready), 32'd0);
    s = 64'({3'b000, 8'hFF, 8'h3C, 4'b0101, 2'b00});
    expect_seq("b2b", s, 25, -1, 8'h00, 13);
    chk_idle("b2b.end");

    // 4: second word 0x01 accepted in tail cycle 2
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    s = 64'({3'b000, 8'h01, 4'b0101, 2'b00, 8'hA5, 4'b0101, 2'b00});
    expect_seq("tail", s, 31, 14, 8'h01, 15);
    chk_idle("tail.end");

    // 5: reset during data bit 4 of 0xA5
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    s = 64'({3'b000, 8'hA5, 4'b0101, 2'b00});
    expect_seq("abort", s, 10, -1, 8'h00, -1);
    chk("abort.bit4", 32'(tx_a), 32'd0);
    chk("abort.oe_before", 32'(tx_oe), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort.ready_rst", 32'(in_ready), 32'd0);
    tick();
    chk_idle("abort.after");
    reset = 1'b0;
    #1;
    chk("abort.ready_rel", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    s = 64'({3'b000, 8'h5A, 4'b0101, 2'b00});
    expect_seq("resume", s, 17, -1, 8'h00, -1);
    chk_idle("resume.end");

    // 6: en low blocks acceptance; en dropped mid-word lets the word finish
    en       = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("en0.ready[%0d]", i), 32'(in_ready), 32'd0);
      tick();
      chk_idle($sformatf("en0[%0d]", i));
    end
    en      = 1'b1;
    in_data = 8'hC3;
    tick();
    s = 64'({3'b000, 8'hC3, 4'b0101, 2'b00});
    expect_seq("endrop.a", s, 9, -1, 8'h00, -1);
    en = 1'b0;
    expect_seq("endrop.b", s >> 9, 8, -1, 8'h00, -1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("endrop.ready[%0d]", i), 32'(in_ready), 32'd0);
      chk_idle($sformatf("endrop.idle[%0d]", i));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
